// File: rtl/core_sequencer_if.sv
// Memory-side handshake bundle for core_sequencer: instruction fetch and data access req/ack.
// The sequencer uses the master modport; memory models or bus adapters use slave.
interface core_sequencer_if;
    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ack,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ack,
        output dmem_ack
    );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle RV32I sequencer: fetch, decode settle, execute, optional memory, writeback.
// Define SEQ_MEM_TIMEOUT_EN to add a memory-ack watchdog that halts with error.
//
// state     | meaning
// ----------+----------------------------------------------
// IDLE      | out of reset, waiting for start
// FETCH     | imem_req held until imem_ack, loads instr reg
// DECODE    | decoder outputs settle; illegal opcode halts
// EXECUTE   | ALU cycle, picks MEM or WRITEBACK
// MEM       | dmem_req held until dmem_ack
// WRITEBACK | pc_we / reg_we strobe, instruction retires
// HALT      | stopped or errored, start resumes at FETCH
module core_sequencer #(
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    core_sequencer_if.master mem,
    output logic             instr_we,
    input  logic             dec_reg_wren,
    input  logic             dec_ram_wren,
    input  logic             dec_load,
    input  logic             dec_illegal,
    output logic             reg_we,
    output logic             pc_we,
    output logic             busy,
    output logic             halted,
    output logic             error,
    output logic [CNT_W-1:0] retire_count,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEM       = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6
    } seq_state_t;

    seq_state_t state_q;
    seq_state_t state_d;
    logic       stop_pending_q;
    logic       set_error;
    logic       wd_expired;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("core_sequencer: TIMEOUT_CYCLES must be at least 1");
    end

`ifdef SEQ_MEM_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_q;

    // Down-counter reloaded on every state change; terminal count means the
    // current FETCH/MEM cycle is the TIMEOUT_CYCLES-th one without an ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q <= '0;
        end else if (state_d != state_q) begin
            wd_q <= WD_W'(TIMEOUT_CYCLES - 1);
        end else if (wd_q != '0) begin
            wd_q <= wd_q - WD_W'(1);
        end
    end

    assign wd_expired = (wd_q == '0);
`else
    assign wd_expired = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        instr_we  = 1'b0;
        set_error = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (mem.imem_ack) begin
                    instr_we = 1'b1;
                    state_d  = S_DECODE;
                end else if (wd_expired) begin
                    state_d   = S_HALT;
                    set_error = 1'b1;
                end
            end
            S_DECODE: begin
                if (dec_illegal) begin
                    state_d   = S_HALT;
                    set_error = 1'b1;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                state_d = (dec_load || dec_ram_wren) ? S_MEM : S_WRITEBACK;
            end
            S_MEM: begin
                if (mem.dmem_ack) begin
                    state_d = S_WRITEBACK;
                end else if (wd_expired) begin
                    state_d   = S_HALT;
                    set_error = 1'b1;
                end
            end
            S_WRITEBACK: begin
                // a stop arriving during the writeback cycle itself still lands in HALT
                state_d = (stop_pending_q || stop) ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                if (start) state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            error          <= 1'b0;
            retire_count   <= '0;
            stop_pending_q <= 1'b0;
        end else begin
            state_q <= state_d;

            if (set_error) begin
                error <= 1'b1;
            end else if (state_q == S_HALT && start) begin
                error <= 1'b0;
            end

            if (state_q == S_WRITEBACK) begin
                retire_count <= retire_count + CNT_W'(1);
            end

            if (state_d == S_HALT) begin
                stop_pending_q <= 1'b0;
            end else if (stop && state_q != S_HALT) begin
                stop_pending_q <= 1'b1;
            end
        end
    end

    assign mem.imem_req = (state_q == S_FETCH);
    assign mem.dmem_req = (state_q == S_MEM);
    assign mem.dmem_we  = (state_q == S_MEM) && dec_ram_wren;
    assign pc_we        = (state_q == S_WRITEBACK);
    assign reg_we       = (state_q == S_WRITEBACK) && dec_reg_wren;
    assign busy         = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted       = (state_q == S_HALT);
    assign state        = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: directed cases plus a randomized instruction stream
// checked against a per-instruction latency/strobe model.
module tb_core_sequencer;

    localparam int TB_CNT_W   = 4;
    localparam int TB_TIMEOUT = 8;
    localparam int CNT_MOD    = 1 << TB_CNT_W;

    localparam int K_ALU     = 0;
    localparam int K_LOAD    = 1;
    localparam int K_STORE   = 2;
    localparam int K_ILLEGAL = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                stop;
    logic                instr_we;
    logic                dec_reg_wren;
    logic                dec_ram_wren;
    logic                dec_load;
    logic                dec_illegal;
    logic                reg_we;
    logic                pc_we;
    logic                busy;
    logic                halted;
    logic                error;
    logic [TB_CNT_W-1:0] retire_count;
    logic [2:0]          state;

    core_sequencer_if bus ();

    core_sequencer #(
        .CNT_W          (TB_CNT_W),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .mem          (bus),
        .instr_we     (instr_we),
        .dec_reg_wren (dec_reg_wren),
        .dec_ram_wren (dec_ram_wren),
        .dec_load     (dec_load),
        .dec_illegal  (dec_illegal),
        .reg_we       (reg_we),
        .pc_we        (pc_we),
        .busy         (busy),
        .halted       (halted),
        .error        (error),
        .retire_count (retire_count),
        .state        (state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_ret = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        check_val("start_fetch_req", 32'(bus.imem_req), 32'd1);
        check_val("start_error_clear", 32'(error), 32'd0);
    endtask

    // Runs one instruction from its first FETCH cycle; id/dd are ack delays in cycles.
    task automatic run_instr(input int kind, input int id, input int dd, input bit rw,
                             input int stop_at, input bit pend);
        bit is_mem;
        bit done;
        bit we_ok;
        bit exp_halt;
        int exp_lat;
        int cyc;
        int f_cnt;
        int m_cnt;
        int iw_cnt;
        int iw_cyc;
        int rw_cnt;
        int pc_cnt;

        is_mem = (kind == K_LOAD) || (kind == K_STORE);
        dec_load     = (kind == K_LOAD);
        dec_ram_wren = (kind == K_STORE);
        dec_reg_wren = rw;
        dec_illegal  = (kind == K_ILLEGAL);
        exp_lat = (kind == K_ILLEGAL) ? id + 2 : id + 1 + 2 + (is_mem ? dd + 1 : 0) + 1;
        done = 0; we_ok = 1; cyc = 0; f_cnt = 0; m_cnt = 0;
        iw_cnt = 0; iw_cyc = -1; rw_cnt = 0; pc_cnt = 0;

        while (!done && cyc < 64) begin
            if (halted) begin
                done = 1;
            end else begin
                bus.imem_ack = 1'b0;
                bus.dmem_ack = 1'b0;
                stop = (cyc == stop_at);
                if (bus.imem_req) begin
                    bus.imem_ack = (f_cnt == id);
                    f_cnt++;
                end
                if (bus.dmem_req) begin
                    bus.dmem_ack = (m_cnt == dd);
                    m_cnt++;
                    if (bus.dmem_we !== (kind == K_STORE)) we_ok = 0;
                end
                #1;
                if (instr_we) begin
                    iw_cnt++;
                    iw_cyc = cyc;
                end
                if (reg_we) rw_cnt++;
                if (pc_we) begin
                    pc_cnt++;
                    done = 1;
                end
                next_cycle();
                cyc++;
            end
        end
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        stop = 1'b0;

        check_val("latency", 32'(cyc), 32'(exp_lat));
        check_val("fetch_cycles", 32'(f_cnt), 32'(id + 1));
        check_val("instr_we_count", 32'(iw_cnt), 32'd1);
        check_val("instr_we_cycle", 32'(iw_cyc), 32'(id));
        if (kind == K_ILLEGAL) begin
            check_val("illegal_pc_we", 32'(pc_cnt), 32'd0);
            check_val("illegal_reg_we", 32'(rw_cnt), 32'd0);
            check_val("illegal_halted", 32'(halted), 32'd1);
            check_val("illegal_error", 32'(error), 32'd1);
            check_val("illegal_dmem", 32'(m_cnt), 32'd0);
            check_val("illegal_retire", 32'(retire_count), 32'(exp_ret % CNT_MOD));
        end else begin
            exp_ret++;
            exp_halt = pend || (stop_at >= 0 && stop_at < exp_lat);
            check_val("dmem_cycles", 32'(m_cnt), 32'(is_mem ? dd + 1 : 0));
            check_val("dmem_we_stable", 32'(we_ok), 32'd1);
            check_val("reg_we_count", 32'(rw_cnt), 32'(rw));
            check_val("pc_we_count", 32'(pc_cnt), 32'd1);
            check_val("retire_count", 32'(retire_count), 32'(exp_ret % CNT_MOD));
            check_val("halted_after_wb", 32'(halted), 32'(exp_halt));
            if (!exp_halt) check_val("next_fetch", 32'(bus.imem_req), 32'd1);
        end
    endtask

    initial begin
        int kind;
        int id;
        int dd;
        bit rw;
        int stop_at;
        int r;

        rst = 1'b1; start = 1'b0; stop = 1'b0;
        dec_reg_wren = 1'b0; dec_ram_wren = 1'b0; dec_load = 1'b0; dec_illegal = 1'b0;
        bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
        repeat (3) next_cycle();

        check_val("rst_state", 32'(state), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_halted", 32'(halted), 32'd0);
        check_val("rst_error", 32'(error), 32'd0);
        check_val("rst_retire", 32'(retire_count), 32'd0);
        check_val("rst_imem_req", 32'(bus.imem_req), 32'd0);
        check_val("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
        check_val("rst_strobes", 32'({pc_we, reg_we, instr_we}), 32'd0);
        rst = 1'b0;
        next_cycle();
        check_val("idle_state", 32'(state), 32'd0);

        // ADDI, LW with 3-cycle dmem delay, SW, then an illegal opcode
        start_run();
        check_val("fetch_state", 32'(state), 32'd1);
        check_val("fetch_busy", 32'(busy), 32'd1);
        run_instr(K_ALU, 0, 0, 1'b1, -1, 1'b0);
        run_instr(K_LOAD, 0, 3, 1'b1, -1, 1'b0);
        run_instr(K_STORE, 1, 0, 1'b0, -1, 1'b0);
        run_instr(K_ILLEGAL, 0, 0, 1'b1, -1, 1'b0);
        check_val("halt_state", 32'(state), 32'd6);
        check_val("halt_busy", 32'(busy), 32'd0);
        start_run();
        check_val("restart_halted", 32'(halted), 32'd0);

        // start and stop together in IDLE: exactly one retirement, then HALT
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        exp_ret = 0;
        check_val("rst_retire_again", 32'(retire_count), 32'd0);
        start = 1'b1; stop = 1'b1;
        next_cycle();
        start = 1'b0; stop = 1'b0;
        run_instr(K_ALU, 1, 0, 1'b1, -1, 1'b1);
        check_val("start_stop_halted", 32'(halted), 32'd1);

        // walk retire_count up to its maximum, then one more wraps to zero
        start_run();
        while ((exp_ret % CNT_MOD) != CNT_MOD - 1) run_instr(K_ALU, 0, 0, 1'b0, -1, 1'b0);
        run_instr(K_ALU, 0, 0, 1'b1, -1, 1'b0);
        check_val("retire_wrap_zero", 32'(retire_count), 32'd0);

        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 3 || r == 9) kind = K_ALU;
            else if (r <= 5)      kind = K_LOAD;
            else if (r <= 7)      kind = K_STORE;
            else                  kind = K_ILLEGAL;
            id = $urandom_range(0, 3);
            dd = $urandom_range(0, 3);
            rw = (kind == K_STORE) ? 1'b0 : 1'($urandom_range(0, 1));
            stop_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 9) : -1;
            run_instr(kind, id, dd, rw, stop_at, 1'b0);
            if (halted) start_run();
        end

        // reset while a load waits in MEM
        dec_load = 1'b1; dec_ram_wren = 1'b0; dec_illegal = 1'b0; dec_reg_wren = 1'b1;
        bus.imem_ack = 1'b1;
        next_cycle();
        bus.imem_ack = 1'b0;
        repeat (2) next_cycle();
        check_val("mid_mem_req", 32'(bus.dmem_req), 32'd1);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        exp_ret = 0;
        check_val("mid_rst_state", 32'(state), 32'd0);
        check_val("mid_rst_dmem_req", 32'(bus.dmem_req), 32'd0);
        check_val("mid_rst_retire", 32'(retire_count), 32'd0);
        check_val("mid_rst_strobes", 32'({pc_we, reg_we}), 32'd0);
        dec_load = 1'b0; dec_reg_wren = 1'b0;
        next_cycle();

`ifdef SEQ_MEM_TIMEOUT_EN
        begin
            int f_cnt;
            f_cnt = 0;
            start_run();
            while (!halted && f_cnt < 40) begin
                if (bus.imem_req) f_cnt++;
                next_cycle();
            end
            check_val("timeout_fetch_cycles", 32'(f_cnt), 32'(TB_TIMEOUT));
            check_val("timeout_halted", 32'(halted), 32'd1);
            check_val("timeout_error", 32'(error), 32'd1);
            check_val("timeout_req_dropped", 32'(bus.imem_req), 32'd0);
            check_val("timeout_retire", 32'(retire_count), 32'd0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control FSM that sequences the RV32I datapath: instruction fetch, decode settle, ALU execute, optional data-memory access, writeback/PC update. Sits between the instruction decoder and the instruction/data memory ports. Consumes the decoder's per-instruction control summary and generates the one-cycle write strobes (instruction register, PC, register file) plus req/ack handshakes toward both memories. Also provides run/stop control, a retired-instruction counter and an error/halt status.

## Interface
- CNT_W, 32, width of retire_count
- TIMEOUT_CYCLES, 256, memory-ack watchdog limit (used only with SEQ_MEM_TIMEOUT_EN)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin execution from IDLE or HALT
- stop  in  1  request halt at the next instruction boundary
- imem_req  out  1  instruction fetch request, held until ack
- imem_ack  in  1  instruction word valid this cycle
- instr_we  out  1  load instruction register (pulse)
- dec_reg_wren  in  1  decoder: instruction writes rd
- dec_ram_wren  in  1  decoder: instruction is a store
- dec_load  in  1  decoder: rd data sourced from RAM
- dec_illegal  in  1  decoder: opcode/funct not recognised
- dmem_req  out  1  data access request, held until ack
- dmem_we  out  1  store qualifier, valid while dmem_req=1
- dmem_ack  in  1  data access complete this cycle
- reg_we  out  1  register-file write strobe (pulse)
- pc_we  out  1  PC update strobe (pulse)
- busy  out  1  state not IDLE/HALT
- halted  out  1  state is HALT
- error  out  1  sticky: illegal instruction or watchdog timeout
- retire_count  out  CNT_W  instructions retired
- state  out  3  debug encoding: IDLE=0 FETCH=1 DECODE=2 EXECUTE=3 MEM=4 WRITEBACK=5 HALT=6

## Operation
- Reset: state=IDLE; all outputs 0; retire_count=0; error=0; stop_pending=0; watchdog=0.
- IDLE: start=1 -> FETCH.
- FETCH: imem_req=1. imem_ack=1 -> instr_we=1 same cycle (combinational), next DECODE. No ack -> stay.
- DECODE: one cycle for decoder outputs to settle. dec_illegal=1 -> HALT, error<=1, no pc_we/reg_we. Else -> EXECUTE.
- EXECUTE: one cycle. dec_load|dec_ram_wren -> MEM, else -> WRITEBACK.
- MEM: dmem_req=1, dmem_we=dec_ram_wren. dmem_ack=1 -> WRITEBACK.
- WRITEBACK: pc_we=1; reg_we=dec_reg_wren; retire_count+1 (wraps 2^CNT_W-1 -> 0). Next: stop_pending -> HALT (stop_pending cleared), else FETCH.
- HALT: halted=1. start=1 -> FETCH, error cleared, watchdog cleared.
- stop_pending set when stop=1 in any state except HALT (incl. the WRITEBACK cycle itself, which then goes to HALT). Start and stop together in IDLE: start wins; exactly one instruction retires, then HALT.
- imem_ack outside FETCH and dmem_ack outside MEM are ignored.
- Decoder inputs sampled only in DECODE/EXECUTE/MEM/WRITEBACK; must stay stable from instr_we until pc_we.
- dec_ram_wren & dec_reg_wren never both 1 for legal instructions; if both, reg_we still follows dec_reg_wren.
- rst mid-instruction: next cycle IDLE, no strobe, pending req dropped, retire_count=0.

## Timing
- Outputs other than instr_we are decoded from registered state (Moore); instr_we = FETCH & imem_ack.
- Minimum latency with ack in first request cycle: ALU/branch/jump 4 cycles (F,D,E,W); load/store 5 cycles (F,D,E,M,W).
- Each memory wait cycle adds one cycle; req stays high and dmem_we stable throughout.
- pc_we and reg_we are exactly one cycle wide, coincident, once per retired instruction.
- retire_count visible incremented the cycle after WRITEBACK.

## Configuration
- SEQ_MEM_TIMEOUT_EN defined: watchdog counts consecutive cycles in FETCH or MEM without ack, resets on every state change. Reaching TIMEOUT_CYCLES -> HALT, error<=1, req dropped the next cycle; no strobes.
- Undefined: no watchdog logic; FETCH/MEM wait indefinitely; error only from dec_illegal.

## Test plan
- Reset, start, ADDI with imem_ack immediate, dec_reg_wren=1 -> instr_we at cycle 1, pc_we=reg_we=1 at cycle 4, retire_count=1.
- LW with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, reg_we at 8th cycle, retire_count increments once.
- SW (dec_ram_wren=1, dec_reg_wren=0) -> dmem_we=1 during MEM, pc_we=1, reg_we=0.
- dec_illegal=1 in DECODE -> HALT, error=1, halted=1, retire_count unchanged; start -> FETCH, error=0.
- start+stop same cycle in IDLE -> one retirement, then halted=1; preset retire_count to 2^CNT_W-1 via run -> wraps to 0.
- With SEQ_MEM_TIMEOUT_EN, TIMEOUT_CYCLES=8, imem_ack held 0 -> HALT with error=1 after 8 FETCH cycles; rst mid-MEM -> IDLE, dmem_req=0 next cycle.
